flash_addr_ctrl: RTL
====================

FLASH_ADDR_CTRL -- requirements
Module: flash_addr_ctrl

Interface
REQ-001 Parameter ADDR_W, default 23, flash word-address width.
REQ-002 Parameter START_ADDR, default 23'h0, first word address of the audio region.
REQ-003 Parameter END_ADDR, default 23'h7FFFF, last word address of the audio region.
REQ-004 CLK_50M  input  1  system clock; the only clock; all logic on its rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 new_addr  input  1  level request from the flash reader for the next word address; held high until addr_out is seen.
REQ-007 direction  input  1  1 = forward (increment), 0 = backward (decrement); sampled at each update.
REQ-008 restart  input  1  one-cycle pulse; reload the start point for the current direction.
REQ-009 flash_addr  output  ADDR_W  current word address presented to flash.
REQ-010 addr_out  output  1  one-cycle acknowledge; flash_addr is already updated and stable while it is high.
REQ-011 wrapped  output  1  one-cycle pulse, coincident with addr_out, when the update wrapped around the region.

Function
REQ-012 FSM states SHALL be IDLE, UPDATE, ACK, WAIT_LOW.
REQ-013 IDLE: new_addr=1 -> UPDATE; else remain in IDLE.
REQ-014 UPDATE: forward, flash_addr = (flash_addr==END_ADDR) ? START_ADDR : flash_addr+1; backward, flash_addr = (flash_addr==START_ADDR) ? END_ADDR : flash_addr-1; next state ACK.
REQ-015 ACK: addr_out=1 for exactly this cycle; wrapped=1 in this cycle if the preceding UPDATE took a wrap branch; next state WAIT_LOW.
REQ-016 WAIT_LOW: new_addr=0 -> IDLE; new_addr=1 -> remain; no further address change.
REQ-017 Latency: new_addr first sampled high in IDLE at cycle N -> flash_addr new value from cycle N+2 -> addr_out high in cycle N+2 only.
REQ-018 A new_addr level held high for any duration SHALL produce exactly one address update.
REQ-019 Address arithmetic SHALL be ADDR_W-bit unsigned; the wrap branches SHALL be the only path from START_ADDR backward or from END_ADDR forward.
REQ-020 restart SHALL take priority in every state: flash_addr = direction ? START_ADDR : END_ADDR; next state IDLE; addr_out and wrapped stay 0 that cycle.
REQ-021 If new_addr is still high in IDLE after a restart, it SHALL be serviced as a new request.
REQ-022 restart and new_addr rising in the same IDLE cycle: restart wins; the request is serviced from the next cycle, from the reloaded address.
REQ-023 A direction change mid-handshake SHALL affect only the next UPDATE.
REQ-024 addr_out and wrapped SHALL never be high outside ACK.

Reset
REQ-025 RST_N=0 at a clock edge: state IDLE, flash_addr=START_ADDR, addr_out=0, wrapped=0.
REQ-026 Reset SHALL override restart and any in-flight handshake; no addr_out pulse follows reset.

Structure
REQ-027 Package flash_addr_pkg SHALL hold the FSM state enum, ADDR_W, and the default START_ADDR/END_ADDR constants.
REQ-028 Single module; next-address logic inline; no sub-module.
REQ-029 addr_out and wrapped SHALL be glitch-free, decoded from registered state and a registered wrap flag.

Verification
REQ-030 Reset: RST_N low 2 cycles -> flash_addr=0, addr_out=0, wrapped=0, state IDLE.
REQ-031 Forward: direction=1, three new_addr handshakes from 0 -> flash_addr 1, 2, 3; each addr_out one cycle at N+2; wrapped=0.
REQ-032 Wrap: flash_addr=0x7FFFF forward -> 0 with wrapped=1; flash_addr=0 backward -> 0x7FFFF with wrapped=1; flash_addr=5 backward -> 4, wrapped=0.
REQ-033 Hold: new_addr high 10 cycles from flash_addr=7 -> flash_addr=8, exactly one addr_out.
REQ-034 Restart: direction=0, restart during UPDATE -> flash_addr=0x7FFFF, no addr_out; new_addr still high -> next handshake gives 0x7FFFE.
REQ-035 Collision: restart and new_addr same IDLE cycle, direction=1, flash_addr=0x100 -> flash_addr=0 then 1, one addr_out.

Source files
------------

// File: rtl/flash_addr_pkg.sv
// flash_addr_pkg: shared state type, width and default region bounds for flash_addr_ctrl
package flash_addr_pkg;
  localparam int FA_ADDR_W = 23;
  localparam logic [FA_ADDR_W-1:0] FA_START_ADDR = 23'h0;
  localparam logic [FA_ADDR_W-1:0] FA_END_ADDR = 23'h7FFFF;
  typedef enum logic [1:0] {IDLE, UPDATE, ACK, WAIT_LOW} fa_state_e;
endpackage

// File: rtl/flash_addr_ctrl.sv
// flash_addr_ctrl: steps a wrapping flash word address forward/backward, one step per new_addr handshake
// Ports: CLK_50M clock; RST_N sync active-low reset; new_addr level request; direction 1=fwd 0=bwd;
//        restart pulse reloads the start point; flash_addr current address; addr_out one-cycle ack;
//        wrapped one-cycle pulse with addr_out when the step wrapped around the region.
module flash_addr_ctrl
  import flash_addr_pkg::*;
#(
  parameter int ADDR_W = FA_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FA_START_ADDR),
  parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(FA_END_ADDR)
) (
  input  logic              CLK_50M,
  input  logic              RST_N,
  input  logic              new_addr,
  input  logic              direction,
  input  logic              restart,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              addr_out,
  output logic              wrapped
);
  fa_state_e r_state, w_state_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic r_wrap, w_wrap_nx;
  logic w_wrap_hit;
  assign w_wrap_hit = direction ? (r_addr == END_ADDR) : (r_addr == START_ADDR);
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx = r_addr;
    w_wrap_nx = r_wrap;
    if (restart) begin
      w_state_nx = IDLE;
      w_addr_nx = direction ? START_ADDR : END_ADDR;
      w_wrap_nx = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: w_state_nx = new_addr ? UPDATE : IDLE;
        UPDATE: begin
          w_state_nx = ACK;
          w_wrap_nx = w_wrap_hit;
          w_addr_nx = direction ? (w_wrap_hit ? START_ADDR : r_addr + ADDR_W'(1))
                                : (w_wrap_hit ? END_ADDR : r_addr - ADDR_W'(1));
        end
        ACK: w_state_nx = WAIT_LOW;
        WAIT_LOW: w_state_nx = new_addr ? WAIT_LOW : IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_addr <= START_ADDR;
      r_wrap <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr <= w_addr_nx;
      r_wrap <= w_wrap_nx;
    end
  end
  assign flash_addr = r_addr;
  assign addr_out = (r_state == ACK);
  assign wrapped = (r_state == ACK) && r_wrap;
endmodule
